// File: rtl/spi_master_pkg.sv
// Shared constants for the SPI initiator: FSM state encodings, byte width and a sizing helper.
package spi_master_pkg;

    localparam int SPI_BYTE_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;
    localparam logic [2:0] ST_CSIDLE = 3'd5;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_master_clk_gen.sv
// SCK generator: half-period divider plus sck register, emitting rise/fall strobes while enabled.
module spi_master_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic enable,
    output logic sck,
    output logic sck_rise,
    output logic sck_fall
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic             sck_q;
    logic             wrap;

    // Strobes mark the clk_sys edge at which sck changes.
    assign wrap     = enable && (div_q == DIV_MAX);
    assign sck_rise = wrap && !sck_q;
    assign sck_fall = wrap && sck_q;
    assign sck      = sck_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else if (!enable) begin
            div_q <= '0;
            sck_q <= 1'b0;
        end else if (wrap) begin
            div_q <= '0;
            sck_q <= ~sck_q;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator with valid/ready byte input and rx_valid pulse per received byte.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting; default is MSB first.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_last,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sck,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso
);
    localparam int CNT_W = $clog2(max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE) + 1);
    localparam logic [CNT_W-1:0] SETUP_MAX = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(CS_IDLE - 1);

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [2:0]            bit_cnt_q;
    logic [SPI_BYTE_W-1:0] tx_sr_q, rx_sr_q, rx_data_q;
    logic [SPI_BYTE_W-1:0] tx_sr_next, rx_sr_next;
    logic                  last_q, ready_q, rx_valid_q, cs_n_q, mosi_q;
    logic                  tx_first_bit, tx_next_bit;
    logic                  accept, clk_en, sck_rise, sck_fall, byte_done;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign tx_first_bit = tx_data[0];
    assign tx_sr_next   = {tx_sr_q[0], tx_sr_q[SPI_BYTE_W-1:1]};
    assign tx_next_bit  = tx_sr_next[0];
    assign rx_sr_next   = {miso, rx_sr_q[SPI_BYTE_W-1:1]};
`else
    assign tx_first_bit = tx_data[SPI_BYTE_W-1];
    assign tx_sr_next   = {tx_sr_q[SPI_BYTE_W-2:0], tx_sr_q[SPI_BYTE_W-1]};
    assign tx_next_bit  = tx_sr_next[SPI_BYTE_W-1];
    assign rx_sr_next   = {rx_sr_q[SPI_BYTE_W-2:0], miso};
`endif

    assign accept    = tx_valid && ready_q;
    assign clk_en    = (state_q == ST_SHIFT);
    assign byte_done = sck_fall && (bit_cnt_q == 3'd7);

    assign tx_ready = ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign cs_n     = cs_n_q;
    assign mosi     = mosi_q;

    spi_master_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .enable  (clk_en),
        .sck     (sck),
        .sck_rise(sck_rise),
        .sck_fall(sck_fall)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  if (cnt_q == SETUP_MAX) state_d = ST_SHIFT;
            ST_SHIFT:  if (byte_done) state_d = last_q ? ST_HOLD : ST_GAP;
            ST_GAP:    if (accept) state_d = ST_SHIFT;
            ST_HOLD:   if (cnt_q == HOLD_MAX) state_d = ST_CSIDLE;
            ST_CSIDLE: if (cnt_q == IDLE_MAX) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == ST_SETUP || state_q == ST_HOLD || state_q == ST_CSIDLE) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the FSM.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ready_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            bit_cnt_q  <= '0;
            last_q     <= 1'b0;
        end else begin
            ready_q    <= (state_d == ST_IDLE) || (state_d == ST_GAP);
            cs_n_q     <= (state_d == ST_IDLE) || (state_d == ST_CSIDLE);
            rx_valid_q <= 1'b0;
            if (state_d == ST_IDLE || state_d == ST_CSIDLE) begin
                mosi_q <= 1'b0;
            end
            if (accept) begin
                tx_sr_q   <= tx_data;
                last_q    <= tx_last;
                mosi_q    <= tx_first_bit;
                bit_cnt_q <= '0;
            end
            if (sck_rise) begin
                rx_sr_q <= rx_sr_next;
            end
            if (sck_fall) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (byte_done) begin
                    rx_valid_q <= 1'b1;
                    rx_data_q  <= rx_sr_q;
                end else begin
                    tx_sr_q <= tx_sr_next;
                    mosi_q  <= tx_next_bit;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback main instance plus a CLK_DIV=1 instance with miso tied high.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_last, tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, busy, sck, cs_n, mosi, miso;

    logic [7:0] f_tx_data;
    logic       f_tx_last, f_tx_valid, f_tx_ready;
    logic [7:0] f_rx_data;
    logic       f_rx_valid, f_busy, f_sck, f_cs_n, f_mosi;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    assign miso = mosi;

    spi_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) u_dut (
        .clk_sys(clk), .reset_n(reset_n), .tx_data(tx_data), .tx_last(tx_last),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .busy(busy), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );

    spi_master #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2), .CS_IDLE(2)) u_dut_fast (
        .clk_sys(clk), .reset_n(reset_n), .tx_data(f_tx_data), .tx_last(f_tx_last),
        .tx_valid(f_tx_valid), .tx_ready(f_tx_ready), .rx_data(f_rx_data),
        .rx_valid(f_rx_valid), .busy(f_busy), .sck(f_sck), .cs_n(f_cs_n), .mosi(f_mosi),
        .miso(1'b1)
    );

    // Bus monitor: counters are cleared by the stimulus through clr.
    logic       clr = 1'b1;
    logic       sck_d = 1'b0, cs_d = 1'b1, rxv_d = 1'b0, f_sck_d = 1'b0;
    logic [7:0] mosi_sr = 8'h00;
    logic [7:0] rx_log [8];
    int n_rise = 0, n_rxv = 0, n_cs_rise = 0, cs_low = 0, hi_run = 0, last_hi = 0;
    int f_rise = 0, f_rxv = 0, f_cs_low = 0;
    logic bad_idle = 1'b0, bad_pulse = 1'b0;

    always @(posedge clk) begin
        sck_d   <= sck;
        cs_d    <= cs_n;
        rxv_d   <= rx_valid;
        f_sck_d <= f_sck;
        if (clr) begin
            n_rise <= 0; n_rxv <= 0; n_cs_rise <= 0; cs_low <= 0; hi_run <= 0; last_hi <= 0;
            f_rise <= 0; f_rxv <= 0; f_cs_low <= 0; bad_idle <= 1'b0; bad_pulse <= 1'b0;
        end else begin
            if (sck && !sck_d) begin
                n_rise  <= n_rise + 1;
                mosi_sr <= {mosi_sr[6:0], mosi};
            end
            if (rx_valid) begin
                rx_log[n_rxv[2:0]] <= rx_data;
                n_rxv <= n_rxv + 1;
            end
            if (rx_valid && rxv_d) bad_pulse <= 1'b1;
            if (cs_n && !cs_d) n_cs_rise <= n_cs_rise + 1;
            if (!cs_n) cs_low <= cs_low + 1;
            if (cs_n) hi_run <= hi_run + 1;
            else if (cs_d) begin
                last_hi <= hi_run;
                hi_run  <= 0;
            end
            if (cs_n && (sck || mosi)) bad_idle <= 1'b1;
            if (f_sck && !f_sck_d) f_rise <= f_rise + 1;
            if (f_rx_valid) f_rxv <= f_rxv + 1;
            if (!f_cs_n) f_cs_low <= f_cs_low + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        while (!tx_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready_timeout", tx_ready, 1'b1);
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        logic stall_bad;
        int   n;
        reset_n    = 1'b0;
        tx_data    = 8'h00; tx_last = 1'b0; tx_valid = 1'b0;
        f_tx_data  = 8'h00; f_tx_last = 1'b0; f_tx_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sck", sck, 1'b0);
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_tx_ready", tx_ready, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", tx_ready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);

        // Single byte 0xA5 in loopback
        clear();
        send(8'hA5, 1'b1);
        chk("a5_ready_drop", tx_ready, 1'b0);
        chk("a5_cs_low_early", cs_n, 1'b0);
        wait_idle();
        chk("a5_cs_low_cycles", cs_low, 68);
        chk("a5_sck_rises", n_rise, 8);
        chk("a5_mosi_bits", mosi_sr, 8'hA5);
        chk("a5_rx_data", rx_data, 8'hA5);
        chk("a5_rx_valid_cnt", n_rxv, 1);
        chk("a5_cs_rise_cnt", n_cs_rise, 1);
        chk("a5_rx_pulse_1cyc", bad_pulse, 1'b0);
        chk("a5_idle_quiet", bad_idle, 1'b0);

        // Three-byte burst
        clear();
        send(8'h01, 1'b0);
        send(8'h80, 1'b0);
        send(8'hFF, 1'b1);
        wait_idle();
        chk("burst_cs_rise_cnt", n_cs_rise, 1);
        chk("burst_sck_rises", n_rise, 24);
        chk("burst_rx_valid_cnt", n_rxv, 3);
        chk("burst_rx0", rx_log[0], 8'h01);
        chk("burst_rx1", rx_log[1], 8'h80);
        chk("burst_rx2", rx_data, 8'hFF);

        // Burst with a 10-cycle stall in GAP
        clear();
        send(8'h5A, 1'b0);
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("gap_reach_timeout", tx_ready, 1'b1);
        stall_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cs_n || sck || !tx_ready || !busy) stall_bad = 1'b1;
        end
        chk("gap_stall_stable", stall_bad, 1'b0);
        chk("gap_rx_first", rx_data, 8'h5A);
        send(8'hC3, 1'b1);
        wait_idle();
        chk("gap_rx_second", rx_data, 8'hC3);
        chk("gap_cs_rise_cnt", n_cs_rise, 1);

        // Back-to-back: tx_valid held through HOLD/CSIDLE must wait for IDLE
        clear();
        send(8'h11, 1'b1);
        tx_data  = 8'h22;
        tx_last  = 1'b1;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_ready_timeout", tx_ready, 1'b1);
        chk("b2b_prev_cs_high", cs_n, 1'b1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        wait_idle();
        chk("b2b_rx_valid_cnt", n_rxv, 2);
        chk("b2b_rx0", rx_log[0], 8'h11);
        chk("b2b_rx1", rx_data, 8'h22);
        chk("b2b_cs_rise_cnt", n_cs_rise, 2);
        chk("b2b_cs_idle_min", 32'(last_hi >= 2), 1);
        chk("b2b_idle_quiet", bad_idle, 1'b0);

        // Reset mid-byte, then a clean byte
        clear();
        send(8'hF0, 1'b1);
        n = 0;
        while (n_rise < 4 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("mid_rise_timeout", 32'(n_rise >= 4), 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", cs_n, 1'b1);
        chk("mid_rst_sck", sck, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        clear();
        send(8'h3C, 1'b1);
        wait_idle();
        chk("mid_rx_data", rx_data, 8'h3C);
        chk("mid_mosi_bits", mosi_sr, 8'h3C);
        chk("mid_rx_valid_cnt", n_rxv, 1);

        // CLK_DIV=1 instance, miso tied high
        clear();
        n = 0;
        while (!f_tx_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("fast_ready_timeout", f_tx_ready, 1'b1);
        f_tx_data  = 8'h96;
        f_tx_last  = 1'b1;
        f_tx_valid = 1'b1;
        @(posedge clk); #1;
        f_tx_valid = 1'b0;
        n = 0;
        while (f_busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("fast_idle_timeout", f_busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("fast_rx_data", f_rx_data, 8'hFF);
        chk("fast_rx_valid_cnt", f_rxv, 1);
        chk("fast_sck_rises", f_rise, 8);
        chk("fast_cs_low_cycles", f_cs_low, 20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
